// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared constants for the bus arbiter/multiplexer slice: the mode encoding on
// the mode input, the arbitration FSM state encoding and the default bus
// geometry (19-bit words, 16 sources, 4-bit select).
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arb_pkg;

  // Selection mode
  localparam logic MODE_DIRECT = 1'b0;   // decoder-driven select
  localparam logic MODE_RR     = 1'b1;   // round-robin arbitration

  // Arbitration FSM states
  localparam logic [0:0] ST_ARB  = 1'b0; // normal selection
  localparam logic [0:0] ST_LOCK = 1'b1; // burst held by the latched owner

  // Default bus geometry
  localparam int DEF_DATA_W = 19;
  localparam int DEF_N_SRC  = 16;
  localparam int DEF_SEL_W  = 4;

endpackage

// File: rtl/bus_arb_mux_if.sv
// -----------------------------------------------------------------------------
// bus_arb_mux_if
// Bundles the source side (mode/sel/req/lock/in_data/gnt) and the consumer
// side (out_valid/out_ready/out_data/out_src) of the shared internal bus.
//   slave  : view taken by bus_arb_mux
//   master : view taken by whatever drives the sources and consumes the bus
// Source i occupies in_data[i*DATA_W +: DATA_W].
// -----------------------------------------------------------------------------
interface bus_arb_mux_if
  import bus_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_SRC  = DEF_N_SRC,
  parameter int SEL_W  = DEF_SEL_W
) ();

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC-1:0]        req;
  logic                    lock;
  logic [N_SRC*DATA_W-1:0] in_data;
  logic [N_SRC-1:0]        gnt;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_src;

  modport slave (
    input  mode, sel, req, lock, in_data, out_ready,
    output gnt, out_valid, out_data, out_src
  );

  modport master (
    output mode, sel, req, lock, in_data, out_ready,
    input  gnt, out_valid, out_data, out_src
  );

endinterface

// File: rtl/bus_arb_mux_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first requesting source found
// when scanning i_ptr, i_ptr+1, ... wrapping modulo N_SRC.
//   i_req    : per-source request vector
//   i_ptr    : search start index (always < N_SRC)
//   o_winner : index of the first requester found (0 when none)
//   o_any    : at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  always_comb begin
    int idx;
    idx      = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      // First hit wins; later hits in the scan are lower priority.
      if (!o_any && i_req[idx]) begin
        o_any    = 1'b1;
        o_winner = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
// Registered N_SRC-to-1 bus selector with handshake and burst lock.
// A winner is chosen either directly from sel or by round-robin; the grant is
// issued combinationally in the cycle the output register can load, and the
// winning word appears on out_data one cycle later.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bus_arb_mux_if.slave
//         mode/sel/req/lock/in_data  source side inputs
//         gnt                        one-hot grant (combinational)
//         out_valid/out_ready        consumer handshake
//         out_data/out_src           registered word and the index that drove it
// -----------------------------------------------------------------------------
module bus_arb_mux
  import bus_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_SRC  = DEF_N_SRC,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic          clk,
  input  logic          rst,
  bus_arb_mux_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(N_SRC - 1);

  logic [0:0]        r_state;
  logic [SEL_W-1:0]  r_owner;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_src;

  logic              w_can_load;
  logic              w_dir_hit;
  logic              w_owner_req;
  logic              w_locked;
  logic              w_rr_any;
  logic [SEL_W-1:0]  w_rr_win;
  logic [SEL_W-1:0]  w_winner;
  logic              w_has_win;
  logic              w_grant;
  logic [N_SRC-1:0]  w_gnt;
  logic [DATA_W-1:0] w_win_data;

  rr_picker #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_rr_picker (
    .i_req    (bus.req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_rr_win),
    .o_any    (w_rr_any)
  );

  // Compare against every real source index instead of indexing req[sel]:
  // a select beyond N_SRC-1 then simply never hits, with no wrap to source 0.
  always_comb begin
    w_dir_hit   = 1'b0;
    w_owner_req = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.sel == SEL_W'(i) && bus.req[i]) w_dir_hit   = 1'b1;
      if (r_owner == SEL_W'(i) && bus.req[i]) w_owner_req = 1'b1;
    end
  end

  assign w_can_load = !r_out_valid || bus.out_ready;

  // The lock holds only while the owner keeps both lock and its request up;
  // otherwise this very cycle already arbitrates normally.
  assign w_locked = (r_state == ST_LOCK) && bus.lock && w_owner_req;

  always_comb begin
    if (w_locked) begin
      w_winner  = r_owner;
      w_has_win = 1'b1;
    end else if (bus.mode == MODE_RR) begin
      w_winner  = w_rr_win;
      w_has_win = w_rr_any;
    end else begin
      w_winner  = bus.sel;
      w_has_win = w_dir_hit;
    end
  end

  // Gating with rst keeps gnt low during reset without waiting for an edge.
  assign w_grant = w_has_win && w_can_load && !rst;

  always_comb begin
    w_gnt      = '0;
    w_win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_winner == SEL_W'(i)) begin
        w_gnt[i]   = w_grant;
        w_win_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register / arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      if (w_can_load) begin
        r_out_valid <= w_grant;
        if (w_grant) begin
          r_out_data <= w_win_data;
          r_out_src  <= w_winner;
        end
      end

      // Only arbitrated round-robin grants advance the pointer; grants
      // forced by a held lock leave it where the burst started.
      if (w_grant && !w_locked && bus.mode == MODE_RR) begin
        r_rr_ptr <= (w_rr_win == LAST_SRC) ? '0 : w_rr_win + SEL_W'(1);
      end

      if (w_locked) begin
        r_state <= ST_LOCK;
      end else if (w_grant && bus.lock) begin
        r_state <= ST_LOCK;
        r_owner <= w_winner;
      end else begin
        r_state <= ST_ARB;
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule
